cmb_sequencer: RTL and testbench
================================

CMB_SEQUENCER -- requirements
Module: cmb_sequencer

Interface
REQ-001 Parameter SETTLE, default 2: number of cycles between driving a vector onto cmb_in and sampling cmb_out; legal range 0..255.
REQ-002 Parameter CNT_W, default 16: width of vec_count and err_count.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 vec_valid  input  1  a stimulus vector is offered.
REQ-006 vec_ready  output  1  block accepts a vector this cycle.
REQ-007 vec_data  input  16  stimulus; bit15..bit0 map to datapath inputs a..p.
REQ-008 vec_expect  input  4  expected datapath response; bit3..bit0 map to q,r,s,t.
REQ-009 cmb_in  output  16  registered drive to the combinational datapath inputs a..p, bit15 = a.
REQ-010 cmb_out  input  4  datapath outputs q,r,s,t, bit3 = q.
REQ-011 res_valid  output  1  a captured result is presented.
REQ-012 res_ready  input  1  consumer accepts the result.
REQ-013 res_data  output  4  captured cmb_out.
REQ-014 res_match  output  1  res_data equals the latched expectation.
REQ-015 vec_count  output  CNT_W  number of vectors captured since reset.
REQ-016 err_count  output  CNT_W  number of captures with res_match = 0 since reset.
REQ-017 busy  output  1  high in every state except IDLE.

Function
REQ-018 FSM states: IDLE, SETTLE, CAPTURE, HOLD; exactly one active per cycle.
REQ-019 IDLE: vec_ready = 1; all other states: vec_ready = 0.
REQ-020 Vector accepted only in a cycle with IDLE, vec_valid = 1, and rst = 0.
REQ-021 On acceptance: cmb_in <= vec_data; vec_expect latched internally; settle timer loaded with SETTLE; next state SETTLE if SETTLE > 0, else CAPTURE.
REQ-022 SETTLE: timer decrements once per cycle; state transitions to CAPTURE on the edge where the timer reaches 0; SETTLE state is occupied exactly SETTLE cycles.
REQ-023 CAPTURE: lasts one cycle; on its closing edge res_data <= cmb_out, res_match <= (cmb_out == latched expect), vec_count increments, err_count increments if mismatch, next state HOLD.
REQ-024 Latency: acceptance in cycle 0 -> res_valid = 1 first in cycle SETTLE+2.
REQ-025 HOLD: res_valid = 1; res_data and res_match stable; transitions to IDLE on the edge where res_ready = 1.
REQ-026 res_valid = 0 in IDLE, SETTLE, and CAPTURE.
REQ-027 No overlap: a new vector is not accepted in the HOLD cycle in which res_ready completes the result handshake; the earliest next acceptance is the following IDLE cycle.
REQ-028 cmb_in holds the last accepted vector until the next acceptance or reset; it never changes during SETTLE, CAPTURE, or HOLD.
REQ-029 vec_valid, vec_data, and vec_expect are ignored outside the acceptance cycle.
REQ-030 res_ready is ignored outside HOLD.
REQ-031 vec_count and err_count saturate at 2^CNT_W-1 and never wrap.
REQ-032 cmb_out is sampled only at the closing edge of CAPTURE; changes on cmb_out in other cycles have no effect.

Reset
REQ-033 When rst = 1 at a clock edge: state <= IDLE, cmb_in <= 0, res_data <= 0, res_match <= 0, vec_count <= 0, err_count <= 0, settle timer <= 0, latched expectation <= 0.
REQ-034 Reset values on outputs: vec_ready = 1, res_valid = 0, busy = 0 in the first cycle after reset.
REQ-035 Reset asserted in SETTLE, CAPTURE, or HOLD aborts the operation; no result is presented and no counter is updated for it.
REQ-036 rst has priority over every handshake in the same cycle.

Verification
REQ-037 SETTLE=2; vec_data=16'hFFFF, vec_expect=4'b1100 accepted in cycle 0; datapath model attached -> cmb_in = 16'hFFFF from cycle 1; res_valid rises in cycle 4; res_data = 4'b1100, res_match = 1; vec_count = 1, err_count = 0.
REQ-038 SETTLE=2; vec_data=16'h0000, vec_expect=4'b0000 -> res_data = 4'b0011, res_match = 0, err_count = 1.
REQ-039 res_ready held low 10 cycles in HOLD -> res_valid stays 1 and res_data is stable; vec_valid high during HOLD -> vec_ready = 0 and no acceptance; after res_ready = 1, there is one IDLE cycle before the next acceptance.
REQ-040 SETTLE=0 -> res_valid = 1 in cycle 2 after acceptance; cmb_out glitching during SETTLE under SETTLE=3 -> only the value at the closing edge of CAPTURE is captured.
REQ-041 rst pulsed in the cycle after acceptance, and separately during HOLD -> next cycle IDLE, cmb_in = 0, counters 0, res_valid = 0; rst with vec_valid = 1 -> no acceptance.
REQ-042 CNT_W=2; 5 mismatching vectors -> vec_count = 3 and err_count = 3 after the 3rd and all later captures.

Source files
------------

// File: rtl/cmb_sequencer.sv
// rtl/cmb_sequencer.sv - drives test vectors into a combinational datapath, samples and scores its response
module cmb_sequencer #(
  parameter int SETTLE = 2,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vec_valid,
  output logic             vec_ready,
  input  logic [15:0]      vec_data,
  input  logic [3:0]       vec_expect,
  output logic [15:0]      cmb_in,
  input  logic [3:0]       cmb_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [3:0]       res_data,
  output logic             res_match,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] err_count,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_CAPTURE,
    S_HOLD
  } state_t;

  localparam logic [7:0]       SETTLE_LD = 8'(SETTLE);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           r_state;
  state_t           w_next;
  logic [7:0]       r_timer;
  logic [3:0]       r_expect;
  logic [15:0]      r_cmb_in;
  logic [3:0]       r_res_data;
  logic             r_res_match;
  logic [CNT_W-1:0] r_vec_count;
  logic [CNT_W-1:0] r_err_count;
  logic             w_accept;
  logic             w_mismatch;

  assign w_accept   = (r_state == S_IDLE) && vec_valid;
  assign w_mismatch = (cmb_out != r_expect);

  assign vec_ready  = (r_state == S_IDLE);
  assign busy       = (r_state != S_IDLE);
  assign res_valid  = (r_state == S_HOLD);
  assign cmb_in     = r_cmb_in;
  assign res_data   = r_res_data;
  assign res_match  = r_res_match;
  assign vec_count  = r_vec_count;
  assign err_count  = r_err_count;

  // State register; reset wins over any handshake in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic; SETTLE is skipped entirely when the settle time is zero.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (vec_valid) w_next = (SETTLE_LD != 8'd0) ? S_SETTLE : S_CAPTURE;
      S_SETTLE:  if (r_timer <= 8'd1) w_next = S_CAPTURE;
      S_CAPTURE: w_next = S_HOLD;
      S_HOLD:    if (res_ready) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Vector latch, settle timer, result capture and saturating scoreboard counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_timer     <= 8'd0;
      r_expect    <= 4'd0;
      r_cmb_in    <= 16'd0;
      r_res_data  <= 4'd0;
      r_res_match <= 1'b0;
      r_vec_count <= '0;
      r_err_count <= '0;
    end else begin
      if (w_accept) begin
        r_cmb_in <= vec_data;
        r_expect <= vec_expect;
        r_timer  <= SETTLE_LD;
      end
      if (r_state == S_SETTLE && r_timer != 8'd0) begin
        r_timer <= r_timer - 8'd1;
      end
      if (r_state == S_CAPTURE) begin
        r_res_data  <= cmb_out;
        r_res_match <= ~w_mismatch;
        if (r_vec_count != CNT_MAX) r_vec_count <= r_vec_count + CNT_ONE;
        if (w_mismatch && r_err_count != CNT_MAX) r_err_count <= r_err_count + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_cmb_sequencer.sv
// tb/tb_cmb_sequencer.sv - randomized self-checking bench for cmb_sequencer
module tb_cmb_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        vec_valid = 1'b0;
  logic [15:0] vec_data = 16'd0;
  logic [3:0]  vec_expect = 4'd0;
  logic        res_ready = 1'b0;
  int          sel = 0;
  logic        glitch_en = 1'b0;
  logic [3:0]  glitch_val = 4'd0;

  int pass_cnt = 0;
  int tot_cnt = 0;
  int exp_vc[3];
  int exp_ec[3];

  // Environment datapath attached to cmb_in/cmb_out
  function automatic logic [3:0] dp(input logic [15:0] x);
    logic [3:0] y;
    y[3] = (x[15] & x[14]) | (x[7] & ~x[6]);
    y[2] = (x[13] | x[12]) & ~(x[5] & ~x[4]);
    y[1] = ~(x[11] & x[10]) ^ (x[3] & ~x[2]);
    y[0] = ~(x[9] | x[8]) | (x[1] & ~x[0]);
    return y;
  endfunction

  function automatic int settle_of(input int s);
    return (s == 0) ? 2 : (s == 1) ? 0 : 3;
  endfunction

  function automatic int cmax_of(input int s);
    return (s == 2) ? 3 : 65535;
  endfunction

  // Instance 0: SETTLE=2, instance 1: SETTLE=0, instance 2: SETTLE=3 CNT_W=2
  logic        vv0, vr0, rv0, rm0, bz0;
  logic [15:0] ci0; logic [3:0] co0, rd0; logic [15:0] vc0, ec0;
  logic        vv1, vr1, rv1, rm1, bz1;
  logic [15:0] ci1; logic [3:0] co1, rd1; logic [15:0] vc1, ec1;
  logic        vv2, vr2, rv2, rm2, bz2;
  logic [15:0] ci2; logic [3:0] co2, rd2; logic [1:0] vc2, ec2;

  assign vv0 = vec_valid && (sel == 0);
  assign vv1 = vec_valid && (sel == 1);
  assign vv2 = vec_valid && (sel == 2);
  assign co0 = (glitch_en && sel == 0) ? glitch_val : dp(ci0);
  assign co1 = (glitch_en && sel == 1) ? glitch_val : dp(ci1);
  assign co2 = (glitch_en && sel == 2) ? glitch_val : dp(ci2);

  cmb_sequencer #(.SETTLE(2), .CNT_W(16)) u_s2 (
    .clk(clk), .rst(rst), .vec_valid(vv0), .vec_ready(vr0), .vec_data(vec_data),
    .vec_expect(vec_expect), .cmb_in(ci0), .cmb_out(co0), .res_valid(rv0),
    .res_ready(res_ready), .res_data(rd0), .res_match(rm0), .vec_count(vc0),
    .err_count(ec0), .busy(bz0));

  cmb_sequencer #(.SETTLE(0), .CNT_W(16)) u_s0 (
    .clk(clk), .rst(rst), .vec_valid(vv1), .vec_ready(vr1), .vec_data(vec_data),
    .vec_expect(vec_expect), .cmb_in(ci1), .cmb_out(co1), .res_valid(rv1),
    .res_ready(res_ready), .res_data(rd1), .res_match(rm1), .vec_count(vc1),
    .err_count(ec1), .busy(bz1));

  cmb_sequencer #(.SETTLE(3), .CNT_W(2)) u_s3 (
    .clk(clk), .rst(rst), .vec_valid(vv2), .vec_ready(vr2), .vec_data(vec_data),
    .vec_expect(vec_expect), .cmb_in(ci2), .cmb_out(co2), .res_valid(rv2),
    .res_ready(res_ready), .res_data(rd2), .res_match(rm2), .vec_count(vc2),
    .err_count(ec2), .busy(bz2));

  logic        m_vr, m_rv, m_rm, m_bz;
  logic [15:0] m_ci, m_vc, m_ec;
  logic [3:0]  m_rd;

  always_comb begin
    m_vr = vr0; m_rv = rv0; m_rm = rm0; m_bz = bz0; m_ci = ci0; m_rd = rd0; m_vc = vc0; m_ec = ec0;
    if (sel == 1) begin
      m_vr = vr1; m_rv = rv1; m_rm = rm1; m_bz = bz1; m_ci = ci1; m_rd = rd1; m_vc = vc1; m_ec = ec1;
    end else if (sel == 2) begin
      m_vr = vr2; m_rv = rv2; m_rm = rm2; m_bz = bz2; m_ci = ci2; m_rd = rd2;
      m_vc = {14'd0, vc2}; m_ec = {14'd0, ec2};
    end
  end

  // Full idle-after-reset check on the selected instance; clears the count model.
  task automatic check_cleared(input string tag);
    for (int i = 0; i < 3; i++) begin exp_vc[i] = 0; exp_ec[i] = 0; end
    tot_cnt++;
    if (m_vr !== 1'b1 || m_rv !== 1'b0 || m_bz !== 1'b0 || m_ci !== 16'd0 ||
        m_vc !== 16'd0 || m_ec !== 16'd0 || m_rd !== 4'd0 || m_rm !== 1'b0)
      $display("FAIL %s: vr=%b rv=%b busy=%b cmb_in=%h vc=%0d ec=%0d rd=%h rm=%b, required 1 0 0 0000 0 0 0 0",
               tag, m_vr, m_rv, m_bz, m_ci, m_vc, m_ec, m_rd, m_rm);
    else pass_cnt++;
  endtask

  // One complete vector transaction on the selected instance, starting and ending at a negedge in IDLE.
  task automatic run_vector(input logic [15:0] d, input logic [3:0] e, input int hold, input bit glitch);
    int st;
    int lat;
    bit ok_in;
    bit ok_hold;
    logic [3:0] want;
    st = settle_of(sel);
    want = dp(d);
    lat = -1;
    ok_in = 1'b1;
    ok_hold = 1'b1;
    tot_cnt++;
    if (m_vr !== 1'b1) $display("FAIL ready_idle: vec_ready=%b required 1", m_vr);
    else pass_cnt++;
    vec_valid = 1'b1; vec_data = d; vec_expect = e;
    @(negedge clk);
    for (int k = 1; k <= 300; k++) begin
      if (m_rv === 1'b1) begin lat = k; break; end
      if (m_ci !== d || m_vr !== 1'b0 || m_bz !== 1'b1) ok_in = 1'b0;
      vec_valid = 1'($urandom); vec_data = 16'($urandom); vec_expect = 4'($urandom);
      res_ready = 1'($urandom);
      if (glitch) begin glitch_en = (k != st + 1); glitch_val = 4'($urandom); end
      @(negedge clk);
    end
    glitch_en = 1'b0; vec_valid = 1'b0; res_ready = 1'b0;
    tot_cnt++;
    if (lat != st + 2) $display("FAIL latency: res_valid after %0d cycles required %0d", lat, st + 2);
    else pass_cnt++;
    tot_cnt++;
    if (!ok_in) $display("FAIL settle_state: cmb_in/vec_ready/busy not steady while busy (cmb_in=%h required %h)", m_ci, d);
    else pass_cnt++;
    if (exp_vc[sel] < cmax_of(sel)) exp_vc[sel]++;
    if (want != e && exp_ec[sel] < cmax_of(sel)) exp_ec[sel]++;
    tot_cnt++;
    if (m_rd !== want || m_rm !== (want == e))
      $display("FAIL result: res_data=%b res_match=%b required %b %b", m_rd, m_rm, want, (want == e));
    else pass_cnt++;
    tot_cnt++;
    if (m_vc !== 16'(exp_vc[sel]) || m_ec !== 16'(exp_ec[sel]))
      $display("FAIL counters: vec_count=%0d err_count=%0d required %0d %0d", m_vc, m_ec, exp_vc[sel], exp_ec[sel]);
    else pass_cnt++;
    for (int h = 0; h < hold; h++) begin
      vec_valid = 1'b1; vec_data = 16'($urandom); res_ready = 1'b0;
      @(negedge clk);
      if (m_rv !== 1'b1 || m_vr !== 1'b0 || m_rd !== want || m_ci !== d) ok_hold = 1'b0;
    end
    tot_cnt++;
    if (!ok_hold) $display("FAIL hold_stable: rv=%b vr=%b rd=%b cmb_in=%h required 1 0 %b %h", m_rv, m_vr, m_rd, m_ci, want, d);
    else pass_cnt++;
    res_ready = 1'b1; vec_valid = 1'b1; vec_data = ~d;
    @(negedge clk);
    res_ready = 1'b0; vec_valid = 1'b0;
    tot_cnt++;
    if (m_vr !== 1'b1 || m_rv !== 1'b0 || m_bz !== 1'b0 || m_ci !== d)
      $display("FAIL post_hold_idle: vr=%b rv=%b busy=%b cmb_in=%h required 1 0 0 %h", m_vr, m_rv, m_bz, m_ci, d);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    sel = 0; rst = 1'b1; vec_valid = 1'b1; vec_data = 16'hA5A5;
    @(negedge clk);
    rst = 1'b0; vec_valid = 1'b0;
    check_cleared("reset_state");
  endtask

  task automatic test_directed();
    sel = 0;
    run_vector(16'hFFFF, 4'b1100, 0, 1'b0);
    run_vector(16'h0000, 4'b0000, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    sel = 0;
    run_vector(16'($urandom), 4'($urandom), 10, 1'b0);
    run_vector(16'($urandom), 4'($urandom), 1, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++) begin
      logic [15:0] d;
      sel = i % 2;
      d = 16'($urandom);
      run_vector(d, ($urandom_range(0, 1) == 1) ? dp(d) : 4'($urandom), $urandom_range(0, 3), 1'b0);
    end
  endtask

  task automatic test_settle0();
    sel = 1;
    run_vector(16'hFFFF, 4'b1100, 2, 1'b0);
  endtask

  task automatic test_glitch();
    sel = 2;
    for (int i = 0; i < 2; i++) run_vector(16'($urandom), 4'($urandom), 1, 1'b1);
  endtask

  task automatic test_abort();
    bit seen;
    sel = 0;
    vec_valid = 1'b1; vec_data = 16'hFFFF; vec_expect = 4'b1100;
    @(negedge clk);
    vec_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_cleared("abort_settle");
    vec_valid = 1'b1; vec_data = 16'h1234; vec_expect = 4'd0;
    @(negedge clk);
    vec_valid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (m_rv === 1'b1) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    tot_cnt++;
    if (!seen) $display("FAIL abort_reach_hold: res_valid=%b required 1", m_rv);
    else pass_cnt++;
    rst = 1'b1; res_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0; res_ready = 1'b0;
    check_cleared("abort_hold");
    run_vector(16'h0000, 4'b0011, 0, 1'b0);
  endtask

  task automatic test_saturate();
    sel = 2; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_cleared("sat_reset");
    for (int i = 0; i < 5; i++) begin
      logic [15:0] d;
      d = 16'($urandom);
      run_vector(d, ~dp(d), 0, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_settle0();
    test_random();
    test_glitch();
    test_abort();
    test_saturate();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
